// File: rtl/stopwatch_pkg.sv
// Purpose: shared state/command encodings and priority helper for the stopwatch control block.
// Latency: none; types, constants and a pure function only.
// Backpressure: none; command inputs are level-sampled and never stalled.
package stopwatch_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 2'b00,
    ST_RUNNING = 2'b01,
    ST_PAUSED  = 2'b10,
    ST_LAP     = 2'b11
  } sw_state_e;

  typedef enum logic [2:0] {
    CMD_NONE  = 3'd0,
    CMD_RESET = 3'd1,
    CMD_STOP  = 3'd2,
    CMD_START = 3'd3,
    CMD_LAP   = 3'd4
  } sw_cmd_e;

  // Same-cycle command priority, highest first.
  localparam int NUM_CMD = 4;
  localparam sw_cmd_e CMD_PRIO [NUM_CMD] = '{CMD_RESET, CMD_STOP, CMD_START, CMD_LAP};

  // Collapse simultaneous commands to the single winning command.
  function automatic sw_cmd_e resolve_cmd(input logic do_reset, input logic do_stop,
                                          input logic do_start, input logic do_lap);
    logic [7:0] req;
    sw_cmd_e    win;
    req            = '0;
    req[CMD_RESET] = do_reset;
    req[CMD_STOP]  = do_stop;
    req[CMD_START] = do_start;
    req[CMD_LAP]   = do_lap;
    win            = CMD_NONE;
    // Walk lowest to highest so the highest-priority request is written last.
    for (int i = NUM_CMD - 1; i >= 0; i--) begin
      if (req[CMD_PRIO[i]]) win = CMD_PRIO[i];
    end
    return win;
  endfunction

endpackage

// File: rtl/stopwatch_ch_fsm.sv
// Purpose: one stopwatch channel: idle/run/pause(/lap) FSM, pause timeout, clear and lap pulses.
// Latency: state and pulses registered, visible the cycle after a command is sampled.
// Backpressure: none; every command is acted on in the cycle it is sampled. Lap via STOPWATCH_LAP_EN.
module stopwatch_ch_fsm
  import stopwatch_pkg::*;
#(
  parameter int IDLE_TIMEOUT = 60,
  parameter int TO_W         = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               reset,
  input  logic               lap,
  input  logic               tick,
  output logic [STATE_W-1:0] state,
  output logic               enable_counting,
  output logic               clear_count,
  output logic               freeze_display,
  output logic               lap_strobe
);

  localparam bit              TO_EN   = (IDLE_TIMEOUT > 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT - 1 : 0);
  localparam logic [TO_W-1:0] TO_SAT  = TO_W'(IDLE_TIMEOUT);

  sw_state_e       state_q, state_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            clear_q, clear_d;
  logic            strobe_q, strobe_d;
  logic            lap_in;
  logic            expire;
  sw_cmd_e         cmd;

`ifdef STOPWATCH_LAP_EN
  assign lap_in = lap;
`else
  // Without the lap feature the command is dropped before priority resolution.
  logic unused_lap;
  assign unused_lap = lap;
  assign lap_in     = 1'b0;
`endif

  // Next-state, timeout and pulse computation for this channel.
  always_comb begin
    cmd      = resolve_cmd(reset, stop, start, lap_in);
    expire   = TO_EN && tick && (to_cnt_q == TO_LAST);
    state_d  = state_q;
    strobe_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd == CMD_START) state_d = ST_RUNNING;
      end
      ST_RUNNING: begin
        case (cmd)
          CMD_RESET: state_d = ST_IDLE;
          CMD_STOP:  state_d = ST_PAUSED;
          CMD_LAP: begin
            state_d  = ST_LAP;
            strobe_d = 1'b1;
          end
          default:   state_d = ST_RUNNING;
        endcase
      end
      ST_PAUSED: begin
        // Stop/lap are holds here, so the timeout can still fire under them.
        if (cmd == CMD_RESET)      state_d = ST_IDLE;
        else if (cmd == CMD_START) state_d = ST_RUNNING;
        else if (expire)           state_d = ST_IDLE;
      end
      ST_LAP: begin
        case (cmd)
          CMD_RESET: state_d = ST_IDLE;
          CMD_STOP:  state_d = ST_PAUSED;
          CMD_START: state_d = ST_RUNNING;
          CMD_LAP:   strobe_d = 1'b1;
          default:   state_d = ST_LAP;
        endcase
      end
      default: state_d = ST_IDLE;
    endcase

    // Only a departure into IDLE clears the counter; reset release does not.
    clear_d = (state_d == ST_IDLE) && (state_q != ST_IDLE);

    // Count ticks only while staying paused; any exit or non-paused cycle zeroes it.
    if ((state_q != ST_PAUSED) || (state_d != ST_PAUSED)) begin
      to_cnt_d = '0;
    end else if (TO_EN && tick && (to_cnt_q != TO_SAT)) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end else begin
      to_cnt_d = to_cnt_q;
    end
  end

  // Channel state, timeout counter and registered pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      to_cnt_q <= '0;
      clear_q  <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      to_cnt_q <= to_cnt_d;
      clear_q  <= clear_d;
      strobe_q <= strobe_d;
    end
  end

  assign state           = state_q;
  assign enable_counting = (state_q == ST_RUNNING) || (state_q == ST_LAP);
  assign clear_count     = clear_q;

`ifdef STOPWATCH_LAP_EN
  assign freeze_display = (state_q == ST_LAP);
  assign lap_strobe     = strobe_q;
`else
  logic unused_strobe;
  assign unused_strobe  = strobe_q;
  assign freeze_display = 1'b0;
  assign lap_strobe     = 1'b0;
`endif

endmodule

// File: rtl/stopwatch_ctrl_mc.sv
// Purpose: NUM_CH independent stopwatch control channels packed onto shared vectors (lap via STOPWATCH_LAP_EN).
// Latency: one cycle from command sample to state/pulse outputs; enable/freeze decode the registered state.
// Backpressure: none; commands are level-sampled every cycle and held commands repeat.
module stopwatch_ctrl_mc
  import stopwatch_pkg::*;
#(
  parameter int NUM_CH       = 2,
  parameter int IDLE_TIMEOUT = 60
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CH-1:0]           start,
  input  logic [NUM_CH-1:0]           stop,
  input  logic [NUM_CH-1:0]           reset,
  input  logic [NUM_CH-1:0]           lap,
  input  logic                        tick,
  output logic [STATE_W*NUM_CH-1:0]   state,
  output logic [NUM_CH-1:0]           enable_counting,
  output logic [NUM_CH-1:0]           clear_count,
  output logic [NUM_CH-1:0]           freeze_display,
  output logic [NUM_CH-1:0]           lap_strobe
);

  localparam int TO_W = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    stopwatch_ch_fsm #(
      .IDLE_TIMEOUT (IDLE_TIMEOUT),
      .TO_W         (TO_W)
    ) u_ch (
      .clk             (clk),
      .rst_n           (rst_n),
      .start           (start[i]),
      .stop            (stop[i]),
      .reset           (reset[i]),
      .lap             (lap[i]),
      .tick            (tick),
      .state           (state[STATE_W*i +: STATE_W]),
      .enable_counting (enable_counting[i]),
      .clear_count     (clear_count[i]),
      .freeze_display  (freeze_display[i]),
      .lap_strobe      (lap_strobe[i])
    );
  end

endmodule

// File: doc/stopwatch_ctrl_mc.md
Name: stopwatch_ctrl_mc

Overview:
- Multi-channel, parametrised successor to the single-channel stopwatch control FSM.
- Runs NUM_CH independent run/pause/idle channel FSMs from per-channel command pulses.
- Adds an auto-idle timeout on paused channels and a one-cycle count-clear pulse.
- Sits between the button/command layer and the per-channel counter/display datapath in the stopwatch top level.

Parameters:
- NUM_CH, 2, number of independent stopwatch channels (1..8).
- IDLE_TIMEOUT, 60, tick pulses spent in PAUSED before forced return to IDLE; 0 disables the timeout.
- TO_W, $clog2(IDLE_TIMEOUT+1) (min 1), width of each channel's timeout counter (derived, not overridden).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  NUM_CH  per-channel start/resume command, one bit per channel, level sampled each clk.
- stop  input  NUM_CH  per-channel pause command.
- reset  input  NUM_CH  per-channel return-to-idle command.
- lap  input  NUM_CH  per-channel lap command (used only with the optional feature).
- tick  input  1  single-cycle timebase pulse, shared by all channels; drives the timeout.
- state  output  2*NUM_CH  channel i state in bits [2i+1:2i]: IDLE=00, RUNNING=01, PAUSED=10, LAP=11.
- enable_counting  output  NUM_CH  1 while channel is RUNNING or LAP.
- clear_count  output  NUM_CH  one-cycle pulse commanding the channel counter to zero.
- freeze_display  output  NUM_CH  1 while channel is LAP.
- lap_strobe  output  NUM_CH  one-cycle pulse commanding a display snapshot of the current count.

Behaviour:
- Reset (rst_n low, asynchronous, any cycle including mid-run):
  - All states go to IDLE.
  - All timeout counters go to 0.
  - clear_count, lap_strobe and freeze_display go to 0.
- Channels are fully independent; commands on channel i never affect channel j.
- Command priority within a channel, same cycle: reset > stop > start > lap.
- Transitions (registered, visible the cycle after the command is sampled):
  - IDLE: start -> RUNNING. Reset, stop and lap are ignored. Stays IDLE otherwise.
  - RUNNING: reset -> IDLE; stop -> PAUSED; lap -> LAP. Start alone holds RUNNING.
  - PAUSED: reset -> IDLE; start -> RUNNING; timeout expiry -> IDLE. Stop and lap hold PAUSED.
  - LAP: reset -> IDLE; stop -> PAUSED; start -> RUNNING; lap -> stay LAP and re-pulse lap_strobe.
- Output timing:
  - enable_counting and freeze_display are combinational decodes of the registered state.
  - clear_count is registered and is high for exactly the first cycle in which state reads IDLE after leaving RUNNING, PAUSED or LAP. It is not asserted after rst_n release.
  - lap_strobe is registered and is high for exactly one cycle, coincident with the first LAP cycle and with each in-LAP lap command.
- Timeout:
  - Counter increments on tick only while PAUSED.
  - Counter clears on any cycle the channel is not PAUSED, including on a PAUSED->RUNNING transition.
  - When the counter equals IDLE_TIMEOUT-1 and tick is high, the channel goes to IDLE and clear_count pulses.
  - Simultaneous start with the expiring tick: start wins, channel goes to RUNNING and the counter clears.
  - With IDLE_TIMEOUT=0 the counter is held at 0 and never expires.
  - Counter saturates, never wraps.
- Held commands act as repeated commands each cycle. In particular, held lap in LAP gives a lap_strobe every cycle. Edge detection is upstream's job.

Optional Feature:
- Macro: STOPWATCH_LAP_EN.
- Defined: LAP state, freeze_display and lap_strobe behave as specified above.
- Undefined:
  - lap is ignored and state never encodes 11.
  - freeze_display and lap_strobe are tied to 0.
  - RUNNING accepts only reset and stop; the remaining transitions are unchanged.

Decomposition:
- Shared package/header stopwatch_pkg holds:
  - the 2-bit state encodings IDLE/RUNNING/PAUSED/LAP;
  - the state width constant;
  - a localparam for the command priority order.
- One sub-module, stopwatch_ch_fsm, contains a single channel's FSM, timeout counter and its clear/lap pulse registers.
- stopwatch_ctrl_mc instantiates NUM_CH copies in a generate loop and packs their outputs onto the vectors.

Test Plan:
- Reset mid-run: ch0 RUNNING, drop rst_n asynchronously between clock edges -> state=0, enable_counting=0 and all pulses 0 immediately; no clear_count after release.
- Basic flow, NUM_CH=2, ch1 only:
  - start[1] -> state[3:2]=01, enable_counting=2'b10.
  - stop[1] -> 10.
  - start[1] -> 01.
  - reset[1] -> 00 with clear_count=2'b10 for one cycle.
  - ch0 stays 00 throughout.
- Priority: RUNNING with start, stop, reset and lap all high in one cycle -> IDLE plus clear_count pulse. With reset low the same cycle -> PAUSED.
- Timeout, IDLE_TIMEOUT=3:
  - ch0 PAUSED, 2 ticks, then start -> RUNNING and counter back to 0.
  - Re-pause, 3 ticks -> IDLE on the cycle after the 3rd tick with clear_count pulse.
  - Start coincident with the 3rd tick -> RUNNING, no clear.
- Lap (macro on):
  - RUNNING + lap -> state 11, lap_strobe 1 cycle, freeze_display 1, enable_counting stays 1.
  - Lap again -> second strobe.
  - Start -> 01, freeze 0.
- Macro off: same lap stimulus -> state stays 01 and lap_strobe/freeze_display stay 0.
